// File: rtl/snake_dir_ctrl_if.sv
// Signal bundle between the key debouncers / game timer and the snake direction controller.
// The slave modport is the controller; the master modport is whoever drives keys, ticks and clears.
interface snake_dir_ctrl_if;
   logic       key_up_flag;
   logic       key_down_flag;
   logic       key_left_flag;
   logic       key_right_flag;
   logic       step_tick;
   logic       game_clr;
   logic [1:0] dir;
   logic       dir_upd;
   logic [2:0] q_level;
   logic       key_drop;

   modport master (
      output key_up_flag, key_down_flag, key_left_flag, key_right_flag,
      output step_tick, game_clr,
      input  dir, dir_upd, q_level, key_drop
   );

   modport slave (
      input  key_up_flag, key_down_flag, key_left_flag, key_right_flag,
      input  step_tick, game_clr,
      output dir, dir_upd, q_level, key_drop
   );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Validates direction key pulses against the last requested heading and queues accepted
// turns; one queued turn is committed to the movement heading per step tick.
module snake_dir_ctrl #(
   parameter int         QUEUE_DEPTH = 2,
   parameter logic [1:0] RESET_DIR   = 2'b11
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   snake_dir_ctrl_if.slave      bus
);

   localparam logic [1:0] LAST_PTR = 2'(QUEUE_DEPTH - 1);
   localparam logic [2:0] FULL_CNT = 3'(QUEUE_DEPTH);

   // Storage is always four entries so 2-bit pointers index it without width games.
   logic [1:0] r_mem [4];
   logic [1:0] r_rd_ptr;
   logic [1:0] r_wr_ptr;
   logic [2:0] r_count;
   logic [1:0] r_dir;
   logic [1:0] r_ref_dir;
   logic       r_dir_upd;
   logic       r_key_drop;

   logic [2:0] w_n_flags;
   logic       w_one_key;
   logic       w_multi_key;
   logic [1:0] w_req;
   logic       w_full;
   logic       w_pop;
   logic       w_turn;
   logic       w_push;
   logic       w_drop;
   logic [2:0] w_count_nxt;

   assign w_n_flags   = 3'(bus.key_up_flag) + 3'(bus.key_down_flag)
                      + 3'(bus.key_left_flag) + 3'(bus.key_right_flag);
   assign w_one_key   = (w_n_flags == 3'd1);
   assign w_multi_key = (w_n_flags >= 3'd2);

   always_comb begin
      w_req = 2'b00;
      if (bus.key_down_flag)       w_req = 2'b01;
      else if (bus.key_left_flag)  w_req = 2'b10;
      else if (bus.key_right_flag) w_req = 2'b11;
   end

   assign w_full = (r_count == FULL_CNT);
   assign w_pop  = bus.step_tick && (r_count != 3'd0);
   // Same heading and reverse heading share the axis bit, so one compare rejects both.
   assign w_turn = w_one_key && (w_req[1] != r_ref_dir[1]);
   assign w_push = w_turn && (!w_full || w_pop);
   assign w_drop = w_multi_key || (w_turn && w_full && !w_pop);
   assign w_count_nxt = r_count + 3'(w_push) - 3'(w_pop);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= 2'b00;
         r_rd_ptr   <= 2'd0;
         r_wr_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_dir      <= RESET_DIR;
         r_ref_dir  <= RESET_DIR;
         r_dir_upd  <= 1'b0;
         r_key_drop <= 1'b0;
      end else if (bus.game_clr) begin
         r_rd_ptr   <= 2'd0;
         r_wr_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_dir      <= RESET_DIR;
         r_ref_dir  <= RESET_DIR;
         r_dir_upd  <= 1'b0;
         r_key_drop <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_req;
            r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? 2'd0 : r_wr_ptr + 2'd1;
            r_ref_dir       <= w_req;
         end
         // A pop alone never moves ref_dir: the tail stays, or the emptied queue's
         // last entry becomes dir, which is the same value.
         if (w_pop) begin
            r_dir    <= r_mem[r_rd_ptr];
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? 2'd0 : r_rd_ptr + 2'd1;
         end
         r_count    <= w_count_nxt;
         r_dir_upd  <= w_pop;
         r_key_drop <= w_drop;
      end
   end

   assign bus.dir      = r_dir;
   assign bus.dir_upd  = r_dir_upd;
   assign bus.q_level  = r_count;
   assign bus.key_drop = r_key_drop;

endmodule
